helai_dvp_tx: RTL and testbench
===============================

// Module: helai_dvp_tx
// PURPOSE
//  DVP (OV5640-style) transmitter: the sending end of the camera parallel bus.
//  Pulls RGB565 pixels from an upstream valid/ready stream and emits
//  VSYNC/HREF/8-bit DATA framing identical to what the OV5640 receive path
//  expects. Used as an on-board sensor emulator and as loopback stimulus for
//  the camera receive chain.
// PARAMETERS
//  IMAGE_WIDTH   1280  active pixels per line (2*IMAGE_WIDTH bytes per line)
//  IMAGE_HEIGHT  720   active lines per frame
//  HBLANK_CYC    256   HREF-low cycles after each line's data (>=2)
//  VSYNC_LINES   4     line periods with VSYNC high at frame start (>=1)
//  VBP_LINES     16    blank line periods after VSYNC, before first active line
//  VFP_LINES     4     blank line periods after last active line
// PORTS
//  clk          in   1   pixel/byte clock; DVP bus sampled by the sink on rising edge
//  rst          in   1   asynchronous reset, active-high
//  en           in   1   level; start frames while high
//  pix_valid    in   1   upstream pixel available
//  pix_data     in   16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}
//  pix_ready    out  1   block consumes pix_data this cycle
//  dvp_vsync    out  1   frame sync, active-high
//  dvp_href     out  1   line data valid, active-high
//  dvp_data     out  8   byte bus
//  frame_done   out  1   1-cycle pulse at end of each frame
//  underflow    out  1   sticky: pixel slot reached with pix_valid low
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; counters 0. Reset mid-frame aborts at once:
//    VSYNC/HREF drop asynchronously, no partial-frame completion.
//  - Line period LP = 2*IMAGE_WIDTH + HBLANK_CYC cycles; hcnt 0..LP-1 wraps,
//    vcnt advances on hcnt wrap. Counter widths $clog2 of max value + 1.
//  - FSM: IDLE -> VSYNC (en=1 sampled in IDLE) -> VBP -> ACTIVE -> VFP ->
//    VSYNC if en=1 at last VFP cycle, else IDLE. State changes only on hcnt
//    wrap where the phase's line count is exhausted. VBP_LINES=0 or
//    VFP_LINES=0 skips that phase. en dropping mid-frame does not truncate the frame.
//  - VSYNC state: dvp_vsync=1, href=0, data=0 for VSYNC_LINES*LP cycles.
//  - ACTIVE line: pix_ready=1 combinationally in cycles where hcnt is even and
//    < 2*IMAGE_WIDTH. All outputs registered: if pix_ready at cycle t, then
//    dvp_data=pix_data[15:8] at t+1 and pix_data[7:0] at t+2, with dvp_href=1
//    at both. HREF stays high for exactly 2*IMAGE_WIDTH contiguous cycles per
//    line, then low for HBLANK_CYC. dvp_data=0 whenever href=0.
//  - Never stalls: pix_ready at a slot with pix_valid=0 sends 16'h0000 for
//    that pixel and sets underflow (cleared only by rst). pix_valid outside a
//    slot is ignored and the pixel is not consumed.
//  - frame_done=1 for the single cycle in which the last VFP line (or the last
//    ACTIVE line if VFP_LINES=0) wraps.
//  - Frame length = (VSYNC_LINES+VBP_LINES+IMAGE_HEIGHT+VFP_LINES)*LP cycles,
//    back to back while en=1.
// TESTING (W=4,H=2,HBLANK=4,VSYNC=1,VBP=1,VFP=1 -> LP=12, frame=60 cycles)
//  1 rst high, en=1 -> all outputs 0; rst release -> VSYNC high 12 cycles,
//    then 12 blank, then first href rise exactly 24 cycles after VSYNC rise.
//  2 pixels 16'hF800,16'h07E0,16'h001F,16'hFFFF always valid -> bytes
//    F8,00,07,E0,00,1F,FF,FF with href high 8 cycles, low 4; 4 pix_ready per line.
//  3 pix_valid=0 on 2nd pixel of line 0 -> bytes 00,00 for it, underflow=1
//    and stays 1 through later frames; line timing unchanged.
//  4 en=1 held -> frame_done every 60 cycles, VSYNC re-rises next cycle;
//    en dropped mid-ACTIVE -> frame completes, then IDLE, VSYNC stays 0.
//  5 rst asserted during href -> href/vsync/data/pix_ready 0 immediately;
//    after release new frame begins with full VSYNC phase.
//  6 VBP_LINES=0, VFP_LINES=0 -> href rises 12 cycles after VSYNC rise; frame=36 cycles.

Source files
------------

// File: rtl/helai_dvp_tx.sv
// ----------------------------------------------------------------------------
// helai_dvp_tx
// DVP (OV5640-style) transmitter. Pulls RGB565 pixels from a valid/ready
// stream and drives VSYNC / HREF / 8-bit DATA framing, high byte first.
// Frame layout in line periods: VSYNC, back porch, active lines, front porch.
// Frames repeat back to back while en is high.
//
// Ports
//   clk        in   pixel/byte clock (sink samples the bus on the rising edge)
//   rst        in   asynchronous reset, active-high; aborts any frame at once
//   en         in   level; frames are started while high
//   pix_valid  in   upstream pixel available
//   pix_data   in   RGB565 pixel {R[4:0],G[5:0],B[4:0]}
//   pix_ready  out  pixel consumed this cycle (combinational)
//   dvp_vsync  out  frame sync, active-high
//   dvp_href   out  line data valid, active-high
//   dvp_data   out  byte bus, 0 whenever dvp_href is low
//   frame_done out  1-cycle pulse after the last line of each frame
//   underflow  out  sticky: a pixel slot was reached with pix_valid low
// ----------------------------------------------------------------------------
module helai_dvp_tx #(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 720,
    parameter int HBLANK_CYC   = 256,
    parameter int VSYNC_LINES  = 4,
    parameter int VBP_LINES    = 16,
    parameter int VFP_LINES    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_done,
    output logic        underflow
);

    localparam int LINE_BYTES = 2 * IMAGE_WIDTH;
    localparam int LP         = LINE_BYTES + HBLANK_CYC;
    localparam int HW         = $clog2(LP);
    localparam int MAX_A      = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
    localparam int MAX_B      = (IMAGE_HEIGHT > VFP_LINES) ? IMAGE_HEIGHT : VFP_LINES;
    localparam int MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int VW         = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(LP - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(LINE_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_ACTIVE,
        S_VFP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [VW-1:0] last_line;
    logic          line_end;
    logic          phase_last;
    logic          in_line;

    logic          vsync_nxt;
    logic          href_nxt;
    logic [7:0]    data_nxt;
    logic          done_nxt;
    logic          underflow_nxt;
    logic [7:0]    lo_byte;
    logic [7:0]    lo_nxt;

    // Index of the final line of the current phase.
    always_comb begin
        last_line = '0;
        case (state)
            S_VSYNC:  last_line = VW'(VSYNC_LINES - 1);
            S_VBP:    last_line = VW'(VBP_LINES - 1);
            S_ACTIVE: last_line = VW'(IMAGE_HEIGHT - 1);
            S_VFP:    last_line = VW'(VFP_LINES - 1);
            default:  last_line = '0;
        endcase
    end

    assign line_end   = (state != S_IDLE) && (hcnt == H_LAST);
    assign phase_last = line_end && (vcnt == last_line);
    assign in_line    = (state == S_ACTIVE) && (hcnt < H_ACT);

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Line / phase counters; held at zero while idle so a frame starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (state == S_IDLE) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (line_end) begin
            hcnt <= '0;
            vcnt <= phase_last ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (en) state_nxt = S_VSYNC;
            end
            S_VSYNC: begin
                if (phase_last) state_nxt = (VBP_LINES > 0) ? S_VBP : S_ACTIVE;
            end
            S_VBP: begin
                if (phase_last) state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (phase_last) begin
                    if (VFP_LINES > 0) state_nxt = S_VFP;
                    else               state_nxt = en ? S_VSYNC : S_IDLE;
                end
            end
            S_VFP: begin
                if (phase_last) state_nxt = en ? S_VSYNC : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // Bus values are computed here and registered below, so the bus lags the
    // counters by one cycle: a pixel taken at cycle t shows its high byte at
    // t+1 and its low byte at t+2.
    always_comb begin
        pix_ready     = in_line && !hcnt[0];
        vsync_nxt     = (state == S_VSYNC);
        href_nxt      = in_line;
        data_nxt      = 8'h00;
        lo_nxt        = lo_byte;
        underflow_nxt = underflow;
        done_nxt      = phase_last &&
                        ((state == S_VFP) || ((state == S_ACTIVE) && (VFP_LINES == 0)));
        if (pix_ready) begin
            // A missing pixel is sent as black; the line timing never stalls.
            data_nxt = pix_valid ? pix_data[15:8] : 8'h00;
            lo_nxt   = pix_valid ? pix_data[7:0]  : 8'h00;
            if (!pix_valid) underflow_nxt = 1'b1;
        end else if (in_line) begin
            data_nxt = lo_byte;
        end
    end

    // NOTE: the async reset clears every output flop, including the low-byte
    // holding register, so a reset mid-line leaves nothing half-sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvp_vsync  <= 1'b0;
            dvp_href   <= 1'b0;
            dvp_data   <= 8'h00;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
            lo_byte    <= 8'h00;
        end else begin
            dvp_vsync  <= vsync_nxt;
            dvp_href   <= href_nxt;
            dvp_data   <= data_nxt;
            frame_done <= done_nxt;
            underflow  <= underflow_nxt;
            lo_byte    <= lo_nxt;
        end
    end

endmodule

// File: tb/tb_helai_dvp_tx.sv
// ----------------------------------------------------------------------------
// tb_helai_dvp_tx
// Bench for helai_dvp_tx. dut_a uses W=4,H=2,HBLANK=4,VSYNC=1,VBP=1,VFP=1
// (line period 12, frame 60). dut_b is the same but with no porches (frame 36).
// A frame-position reference model predicts the framing and pushes expected
// bytes into a queue; a monitor pops and compares whenever HREF is high.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_helai_dvp_tx;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int HB    = 4;
    localparam int VS    = 1;
    localparam int VBP   = 1;
    localparam int VFP   = 1;
    localparam int LP    = 2 * W + HB;
    localparam int FRAME = (VS + VBP + H + VFP) * LP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a
    logic        rst_a = 1'b1;
    logic        en_a  = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data  = 16'h0000;
    logic        a_ready, a_vsync, a_href, a_done, a_uf;
    logic [7:0]  a_dout;

    // dut_b
    logic        rst_b = 1'b1;
    logic        en_b  = 1'b1;
    logic        b_valid = 1'b1;
    logic [15:0] b_pix   = 16'hA55A;
    logic        b_ready, b_vsync, b_href, b_done, b_uf;
    logic [7:0]  b_dout;

    helai_dvp_tx #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK_CYC(HB),
        .VSYNC_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP)
    ) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(a_ready),
        .dvp_vsync(a_vsync), .dvp_href(a_href), .dvp_data(a_dout),
        .frame_done(a_done), .underflow(a_uf)
    );

    helai_dvp_tx #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK_CYC(HB),
        .VSYNC_LINES(VS), .VBP_LINES(0), .VFP_LINES(0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b),
        .pix_valid(b_valid), .pix_data(b_pix), .pix_ready(b_ready),
        .dvp_vsync(b_vsync), .dvp_href(b_href), .dvp_data(b_dout),
        .frame_done(b_done), .underflow(b_uf)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0:       return a_vsync;
            1:       return a_href;
            2:       return a_done;
            3:       return b_vsync;
            4:       return b_href;
            default: return b_done;
        endcase
    endfunction

    // Waits (sampling on falling edges) until the selected output equals
    // level; returns the cycle count, or -1 and a failed check on timeout.
    task automatic wait_for(input int which, input logic level, input int budget, output int at);
        logic found;
        found = 1'b0;
        at    = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sig_of(which) == level) begin
                found = 1'b1;
                at    = cyc;
                break;
            end
        end
        if (!found) check($sformatf("wait_timeout_sig%0d", which), found, 1);
    endtask

    // ---------------- reference model for dut_a ----------------
    // Position p counts cycles from frame start; the bus shows, one cycle
    // later, what the frame layout says about position p.
    function automatic logic m_in_href(input int p);
        int line;
        int col;
        line = p / LP;
        col  = p % LP;
        return (line >= VS + VBP) && (line < VS + VBP + H) && (col < 2 * W);
    endfunction

    function automatic logic m_is_slot(input int p);
        return m_in_href(p) && ((p % LP) % 2 == 0);
    endfunction

    logic        m_run = 1'b0;
    int          m_p   = 0;
    logic        exp_vsync = 1'b0;
    logic        exp_href  = 1'b0;
    logic        exp_done  = 1'b0;
    logic        exp_uf    = 1'b0;
    logic [15:0] m_word;
    logic [7:0]  byteq[$];

    initial begin : ref_model
        forever begin
            @(posedge clk or posedge rst_a);
            if (rst_a) begin
                m_run     = 1'b0;
                m_p       = 0;
                exp_vsync = 1'b0;
                exp_href  = 1'b0;
                exp_done  = 1'b0;
                exp_uf    = 1'b0;
                byteq.delete();
            end else begin
                exp_vsync = m_run && (m_p / LP < VS);
                exp_href  = m_run && m_in_href(m_p);
                exp_done  = m_run && (m_p == FRAME - 1);
                if (m_run && m_is_slot(m_p)) begin
                    m_word = pix_valid ? pix_data : 16'h0000;
                    if (!pix_valid) exp_uf = 1'b1;
                    byteq.push_back(m_word[15:8]);
                    byteq.push_back(m_word[7:0]);
                end
                if (!m_run) begin
                    if (en_a) begin
                        m_run = 1'b1;
                        m_p   = 0;
                    end
                end else if (m_p == FRAME - 1) begin
                    if (en_a) m_p = 0;
                    else      m_run = 1'b0;
                end else begin
                    m_p++;
                end
            end
        end
    end

    // ---------------- monitor for dut_a ----------------
    int         a_ready_cnt = 0;
    logic [7:0] exp_b;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_a) begin
                a_ready_cnt = 0;
                check("rst_ready", a_ready, 0);
                check("rst_vsync", a_vsync, 0);
                check("rst_href",  a_href, 0);
                check("rst_data",  a_dout, 0);
                check("rst_done",  a_done, 0);
                check("rst_uf",    a_uf, 0);
            end else begin
                if (a_ready) a_ready_cnt++;
                check("pix_ready",  a_ready, m_run && m_is_slot(m_p));
                check("vsync",      a_vsync, exp_vsync);
                check("href",       a_href,  exp_href);
                check("frame_done", a_done,  exp_done);
                check("underflow",  a_uf,    exp_uf);
                if (a_href) begin
                    if (byteq.size() == 0) begin
                        check("byte_queue_empty", byteq.size(), 1);
                    end else begin
                        exp_b = byteq.pop_front();
                        check("dvp_data", a_dout, exp_b);
                    end
                end else begin
                    check("data_idle", a_dout, 0);
                end
            end
        end
    end

    // ---------------- upstream pixel source for dut_a ----------------
    // mode 0: fixed pattern always valid; mode 1: same but the second pixel
    // after the mode change is missing; mode 2: random data, random gaps.
    logic [15:0] pat [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
    int          mode     = 0;
    int          src_slot = 0;

    initial begin : source
        forever begin
            @(negedge clk);
            if (a_ready) begin
                case (mode)
                    0: begin
                        pix_valid = 1'b1;
                        pix_data  = pat[src_slot % 4];
                    end
                    1: begin
                        pix_valid = (src_slot != 1);
                        pix_data  = pat[src_slot % 4];
                    end
                    default: begin
                        pix_valid = ($urandom_range(7) != 0);
                        pix_data  = 16'($urandom);
                    end
                endcase
                src_slot++;
            end else begin
                // Offered outside a slot: must be ignored.
                pix_valid = 1'($urandom_range(1));
                pix_data  = 16'($urandom);
            end
        end
    end

    // ---------------- dut_b: porch-free timing ----------------
    int   b_rdy_cnt  = 0;
    logic b_finished = 1'b0;
    always @(negedge clk) if (b_ready) b_rdy_cnt <= b_rdy_cnt + 1;

    initial begin : b_checker
        int t_vs, t_hr, d1, d2, r1, r2;
        @(negedge rst_b);
        wait_for(3, 1'b1, 30, t_vs);
        wait_for(4, 1'b1, 60, t_hr);
        check("b_href_after_vsync", t_hr - t_vs, LP);
        check("b_first_byte", b_dout, 8'hA5);
        wait_for(5, 1'b1, 100, d1);
        r1 = b_rdy_cnt;
        wait_for(5, 1'b1, 100, d2);
        r2 = b_rdy_cnt;
        check("b_frame_len", d2 - d1, (VS + H) * LP);
        check("b_ready_per_frame", r2 - r1, W * H);
        check("b_underflow", b_uf, 0);
        b_finished = 1'b1;
    end

    // ---------------- directed sequence for dut_a ----------------
    logic [7:0] exp_clean [8] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
    logic [7:0] exp_gap   [8] = '{8'hF8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1F, 8'hFF, 8'hFF};

    initial begin : main
        int t0, t1, t2, d1, d2, d3, d4, vs_cnt;
        en_a = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_vsync", a_vsync, 0);
        check("reset_href",  a_href, 0);
        check("reset_data",  a_dout, 0);
        check("reset_ready", a_ready, 0);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Startup timing and first line bytes.
        wait_for(0, 1'b1, 20, t0);
        wait_for(1, 1'b1, 60, t1);
        check("href_after_vsync", t1 - t0, 2 * LP);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("clean_byte%0d", k), a_dout, exp_clean[k]);
            @(negedge clk);
        end
        check("href_low_after_line", a_href, 0);
        wait_for(1, 1'b1, 20, t2);
        check("line_period", t2 - t1, LP);
        wait_for(2, 1'b1, 100, d1);
        check("done_after_vsync", d1 - t0, FRAME - 1);
        check("ready_per_frame", a_ready_cnt, W * H);
        #1;
        mode     = 1;
        src_slot = 0;

        // Missing second pixel in line 0.
        wait_for(1, 1'b1, 60, t1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("gap_byte%0d", k), a_dout, exp_gap[k]);
            @(negedge clk);
        end
        check("underflow_set", a_uf, 1);
        wait_for(2, 1'b1, 100, d2);
        check("frame_period_1", d2 - d1, FRAME);
        check("vsync_low_at_done", a_vsync, 0);
        @(negedge clk);
        check("vsync_rerise", a_vsync, 1);
        #1;
        mode = 2;

        wait_for(2, 1'b1, 100, d3);
        check("frame_period_2", d3 - d2, FRAME);

        // en dropped mid-ACTIVE: frame must still complete, then idle.
        wait_for(1, 1'b1, 60, t1);
        #1;
        en_a = 1'b0;
        wait_for(2, 1'b1, 100, d4);
        check("frame_after_en_drop", d4 - d3, FRAME);
        vs_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (a_vsync) vs_cnt++;
        end
        check("idle_no_vsync", vs_cnt, 0);
        check("underflow_sticky", a_uf, 1);
        #1;
        en_a = 1'b1;

        // Reset during HREF: everything drops without waiting for a clock.
        wait_for(1, 1'b1, 60, t1);
        #2;
        rst_a = 1'b1;
        #1;
        check("midrst_href",  a_href, 0);
        check("midrst_vsync", a_vsync, 0);
        check("midrst_data",  a_dout, 0);
        check("midrst_ready", a_ready, 0);
        check("midrst_uf",    a_uf, 0);
        @(negedge clk);
        #2;
        rst_a = 1'b0;
        wait_for(0, 1'b1, 20, t0);
        wait_for(0, 1'b0, 40, t1);
        check("vsync_width_after_rst", t1 - t0, VS * LP);
        wait_for(2, 1'b1, 100, d1);

        for (int i = 0; i < 500 && !b_finished; i++) @(negedge clk);
        if (!b_finished) check("b_checker_timeout", b_finished, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
